// File: rtl/apple_spawner_pkg.sv
// apple_spawner_pkg: shared grid geometry, bus widths and placement FSM
// encoding for the snake game's apple spawner, snake body and renderer blocks.
package apple_spawner_pkg;

  localparam int unsigned CELL_PX    = 10;
  localparam int unsigned GRID_W     = 64;
  localparam int unsigned GRID_H     = 48;
  localparam int unsigned CELL_W     = 6;
  localparam int unsigned PIX_X_W    = 10;
  localparam int unsigned PIX_Y_W    = 9;
  localparam int unsigned COUNT_W    = 8;
  localparam int unsigned LFSR_W     = 16;
  localparam int unsigned SCAN_LIMIT = GRID_W * GRID_H;

  // Galois feedback mask applied when the bit shifted out is 1.
  localparam logic [LFSR_W-1:0] LFSR_TAPS = 16'hB400;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_DRAW  = 3'd1,
    ST_WAIT  = 3'd2,
    ST_SCAN  = 3'd3,
    ST_PLACE = 3'd4,
    ST_READY = 3'd5
  } spawn_state_e;

endpackage

// File: rtl/apple_spawner_if.sv
// apple_spawner_if: game-side signals of the apple spawner.
//   master (spawner): in  start, eaten, query_hit
//                     out query_x/y, query_req, appleX/Y, apple_valid, busy, apple_count
//   slave  (game/snake/renderer side): the mirror image.
interface apple_spawner_if;
  import apple_spawner_pkg::*;

  logic               start;
  logic               eaten;
  logic [CELL_W-1:0]  query_x;
  logic [CELL_W-1:0]  query_y;
  logic               query_req;
  logic               query_hit;
  logic [PIX_X_W-1:0] appleX;
  logic [PIX_Y_W-1:0] appleY;
  logic               apple_valid;
  logic               busy;
  logic [COUNT_W-1:0] apple_count;

  modport master (
    input  start, eaten, query_hit,
    output query_x, query_y, query_req, appleX, appleY, apple_valid, busy, apple_count
  );

  modport slave (
    output start, eaten, query_hit,
    input  query_x, query_y, query_req, appleX, appleY, apple_valid, busy, apple_count
  );

endinterface

// File: rtl/apple_spawner_lfsr16.sv
// lfsr16: free-running 16-bit Galois LFSR, the spawner's random source.
//   clk   in   clock
//   reset in   synchronous active-high, loads seed
//   seed  in   non-zero reset value
//   out   out  current register value
module lfsr16
  import apple_spawner_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic [LFSR_W-1:0] seed,
  output logic [LFSR_W-1:0] out
);

  logic [LFSR_W-1:0] r_lfsr;

  // Shift right; fold the taps back in when a 1 falls off the bottom.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_lfsr <= seed;
    end else begin
      r_lfsr <= (r_lfsr >> 1) ^ (r_lfsr[0] ? LFSR_TAPS : '0);
    end
  end

  assign out = r_lfsr;

endmodule

// File: rtl/apple_spawner.sv
// apple_spawner: picks a free grid cell for the apple and publishes its pixel
// origin; redraws after every eaten event and counts apples eaten.
//   VGA_clk  in  pixel clock
//   reset    in  synchronous active-high
//   io       apple_spawner_if.master
//     start in (run level), eaten in (pulse), query_hit in (reply 2 cycles
//     after query_req), query_x/y/req out, appleX/appleY out (cell * 10),
//     apple_valid out, busy out, apple_count out (saturating)
module apple_spawner
  import apple_spawner_pkg::*;
#(
  parameter logic [LFSR_W-1:0] LFSR_SEED = 16'hACE1,
  parameter int unsigned       MAX_TRIES = 8
) (
  input  logic                   VGA_clk,
  input  logic                   reset,
  apple_spawner_if.master        io
);

  localparam int unsigned TRIES_W = $clog2(MAX_TRIES + 1);
  localparam int unsigned SCAN_W  = $clog2(SCAN_LIMIT + 1);
  localparam int unsigned WAIT_W  = 2;

  spawn_state_e        r_state;
  logic [CELL_W-1:0]   r_cell_x;
  logic [CELL_W-1:0]   r_cell_y;
  logic                r_query_req;
  logic [PIX_X_W-1:0]  r_apple_x;
  logic [PIX_Y_W-1:0]  r_apple_y;
  logic                r_apple_valid;
  logic                r_busy;
  logic [COUNT_W-1:0]  r_apple_count;
  logic [TRIES_W-1:0]  r_tries;
  logic [WAIT_W-1:0]   r_wait_cnt;
  logic [SCAN_W-1:0]   r_scan_cnt;
  logic                r_pending;

  logic [LFSR_W-1:0]   w_lfsr;
  logic                w_lfsr_unused;
  logic [CELL_W-1:0]   w_cand_x;
  logic [CELL_W-1:0]   w_cand_y;
  logic                w_cand_ok;
  logic                w_x_wrap;
  logic [CELL_W-1:0]   w_scan_x;
  logic [CELL_W-1:0]   w_scan_y;
  logic [PIX_X_W-1:0]  w_px_x;
  logic [PIX_Y_W-1:0]  w_px_y;

  lfsr16 u_lfsr (
    .clk   (VGA_clk),
    .reset (reset),
    .seed  (LFSR_SEED),
    .out   (w_lfsr)
  );

  // Candidate cell straight from the random source; rows >= GRID_H are off-field.
  assign w_cand_x      = w_lfsr[5:0];
  assign w_cand_y      = w_lfsr[11:6];
  assign w_lfsr_unused = ^w_lfsr[15:12];
  assign w_cand_ok     = (w_cand_y < CELL_W'(GRID_H));

  // Raster-order successor of the current cell, wrapping to (0,0) after the last.
  assign w_x_wrap = (r_cell_x == CELL_W'(GRID_W - 1));
  assign w_scan_x = w_x_wrap ? '0 : r_cell_x + CELL_W'(1);
  assign w_scan_y = !w_x_wrap                           ? r_cell_y :
                    (r_cell_y >= CELL_W'(GRID_H - 1))   ? '0       :
                                                          r_cell_y + CELL_W'(1);

  // cell * 10 as (c << 3) + (c << 1); cannot overflow for on-field cells.
  assign w_px_x = (PIX_X_W'(r_cell_x) << 3) + (PIX_X_W'(r_cell_x) << 1);
  assign w_px_y = (PIX_Y_W'(r_cell_y) << 3) + (PIX_Y_W'(r_cell_y) << 1);

  // Placement FSM with all outputs registered.
  always_ff @(posedge VGA_clk) begin
    if (reset) begin
      r_state       <= ST_IDLE;
      r_cell_x      <= '0;
      r_cell_y      <= '0;
      r_query_req   <= 1'b0;
      r_apple_x     <= '0;
      r_apple_y     <= '0;
      r_apple_valid <= 1'b0;
      r_busy        <= 1'b0;
      r_apple_count <= '0;
      r_tries       <= '0;
      r_wait_cnt    <= '0;
      r_scan_cnt    <= '0;
      r_pending     <= 1'b0;
    end else begin
      r_query_req <= 1'b0;

      // Every eaten outside IDLE counts; while placing it is remembered for READY.
      if (io.eaten && (r_state != ST_IDLE)) begin
        if (r_apple_count != '1) begin
          r_apple_count <= r_apple_count + COUNT_W'(1);
        end
        if (r_state != ST_READY) begin
          r_pending <= 1'b1;
        end
      end

      case (r_state)
        ST_IDLE: begin
          if (io.start) begin
            r_busy  <= 1'b1;
            r_state <= ST_DRAW;
          end
        end

        ST_DRAW: begin
          r_cell_x <= w_cand_x;
          r_cell_y <= w_cand_y;
          if (r_tries < TRIES_W'(MAX_TRIES)) begin
            r_tries <= r_tries + TRIES_W'(1);
          end
          if (w_cand_ok) begin
            r_query_req <= 1'b1;
            r_wait_cnt  <= '0;
            r_state     <= ST_WAIT;
          end
        end

        // Two idle cycles, then the snake's reply is sampled.
        ST_WAIT: begin
          if (r_wait_cnt != WAIT_W'(2)) begin
            r_wait_cnt <= r_wait_cnt + WAIT_W'(1);
          end else if (!io.query_hit) begin
            r_state <= ST_PLACE;
          end else if (r_tries < TRIES_W'(MAX_TRIES)) begin
            r_state <= ST_DRAW;
          end else if (r_scan_cnt >= SCAN_W'(SCAN_LIMIT)) begin
            r_state <= ST_PLACE;
          end else begin
            r_state <= ST_SCAN;
          end
        end

        ST_SCAN: begin
          r_cell_x    <= w_scan_x;
          r_cell_y    <= w_scan_y;
          r_scan_cnt  <= r_scan_cnt + SCAN_W'(1);
          r_query_req <= 1'b1;
          r_wait_cnt  <= '0;
          r_state     <= ST_WAIT;
        end

        ST_PLACE: begin
          r_apple_x     <= w_px_x;
          r_apple_y     <= w_px_y;
          r_apple_valid <= 1'b1;
          r_busy        <= 1'b0;
          r_tries       <= '0;
          r_scan_cnt    <= '0;
          r_state       <= ST_READY;
        end

        // A fresh or remembered eaten restarts placement; stopping the game parks in IDLE.
        ST_READY: begin
          if (io.start && (io.eaten || r_pending)) begin
            r_apple_valid <= 1'b0;
            r_busy        <= 1'b1;
            r_pending     <= 1'b0;
            r_state       <= ST_DRAW;
          end else if (!io.start) begin
            r_pending <= 1'b0;
            r_state   <= ST_IDLE;
          end
        end

        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign io.query_x     = r_cell_x;
  assign io.query_y     = r_cell_y;
  assign io.query_req   = r_query_req;
  assign io.appleX      = r_apple_x;
  assign io.appleY      = r_apple_y;
  assign io.apple_valid = r_apple_valid;
  assign io.busy        = r_busy;
  assign io.apple_count = r_apple_count;

endmodule
